// File: rtl/serial_adder.sv
// serial_adder: bit-serial W-bit adder using one full-adder cell and a carry flop.
// Operands are captured on start, added LSB-first one bit per clock, result held after done.
module serial_adder #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state_q, state_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic c_q, c_d, cout_q, cout_d;
   logic s, cy;
   logic [W:0] sh;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         cout_q  <= cout_d;
      end
   end
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      cout_d  = cout_q;
      s       = a_q[0] ^ b_q[0] ^ c_q;
      cy      = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
      sh      = {s, sum_q};
      case (state_q)
         IDLE: if (start) begin
            state_d = SHIFT;
            a_d     = a;
            b_d     = b;
            c_d     = cin;
            cnt_d   = '0;
            sum_d   = '0;
         end
         SHIFT: begin
            sum_d = sh[W:1];
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = cy;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = DONE;
               cout_d  = cy;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder covering timing, exhaustive sums,
// operand isolation, mid-add reset and back-to-back starts.
module tb_serial_adder;
   localparam int W = 4;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic busy, done, cout;
   logic [W-1:0] sum;
   int n_chk = 0, n_err = 0, cyc = 0, last_done = 0;
   logic b2b = 1'b0, gap_ok = 1'b0, prev_done = 1'b0;
   logic [W:0] sb[$];

   serial_adder #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         chk("done_width", {31'b0, prev_done}, 0);
         if (sb.size() == 0) chk("spurious_done", 1, 0);
         else chk("result", {cout, sum}, sb.pop_front());
         if (b2b && gap_ok) chk("b2b_gap", cyc - last_done, W + 2);
         gap_ok    = b2b;
         last_done = cyc;
      end
      prev_done = done;
   end

   task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
      logic [W:0] e;
      e = model(ta, tb_, tc);
      @(negedge clk);
      a = ta; b = tb_; cin = tc; start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
      @(negedge clk);
      chk("sum_clr", sum, 0);
      chk("busy", busy, 1);
      repeat (W - 1) begin
         @(negedge clk);
         chk("busy", busy, 1);
      end
      @(negedge clk);
      chk("done_at", {busy, done}, 2'b01);
      @(negedge clk);
      chk("idle_after", {busy, done}, 2'b00);
      chk("hold", {cout, sum}, e);
   endtask

   initial begin
      logic [W:0] e;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out", {busy, done, cout, sum}, 0);
      rst = 1'b0;
      run_add(4'd7, 4'd9, 1'b0);
      run_add(4'd5, 4'd3, 1'b1);
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(i);
         run_add(v[8:5], v[4:1], v[0]);
      end
      // start held with wandering operands: only the first capture counts
      @(negedge clk);
      a = 4'd3; b = 4'd4; cin = 1'b0; start = 1'b1;
      sb.push_back(model(4'd3, 4'd4, 1'b0));
      @(posedge clk);
      #1;
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk("hold_busy", busy, 1);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      chk("hold_done", done, 1);
      start = 1'b0;
      @(negedge clk);
      chk("hold_no_requeue", {busy, done}, 2'b00);
      @(negedge clk);
      chk("hold_idle", {busy, done}, 2'b00);
      // reset during the second shift cycle
      a = 4'd15; b = 4'd1; cin = 1'b0; start = 1'b1;
      sb.push_back(model(4'd15, 4'd1, 1'b0));
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("midrst_out", {busy, done, cout, sum}, 0);
      rst = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         chk("midrst_no_done", done, 0);
      end
      run_add(4'd2, 4'd2, 1'b0);
      // start held high continuously
      @(negedge clk);
      b2b = 1'b1; gap_ok = 1'b0;
      a = 4'd1; b = 4'd2; cin = 1'b0; start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         e = model(a, b, cin);
         sb.push_back(e);
         @(posedge clk);
         #1 a = a + 4'd5; b = b + 4'd3; cin = ~cin;
         repeat (W) begin
            @(negedge clk);
            chk("b2b_busy", busy, 1);
         end
         @(negedge clk);
         chk("b2b_done", done, 1);
         @(negedge clk);
         chk("b2b_idle", {busy, done}, 2'b00);
         chk("b2b_hold", {cout, sum}, e);
      end
      start = 1'b0;
      b2b = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
